// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card power-up sequencer: dummy clocks, CMD0/CMD8/CMD55+ACMD41/CMD58,
// driven one byte at a time through an external SPI shifter.
module sd_init_sequencer #(
  parameter int DUMMY_BYTES    = 10,
  parameter int RESP_TIMEOUT   = 8,
  parameter int ACMD41_RETRIES = 255
) (
  input  logic       CLKin,
  input  logic       Reset,
  input  logic       Start,
  input  logic       SpiDone,
  input  logic [7:0] SpiRx,
  output logic       SpiStart,
  output logic [7:0] SpiTx,
  output logic       CS_n,
  output logic [7:0] State,
  output logic       Ready,
  output logic       Error,
  output logic       HighCap
);

  localparam int RW = $clog2(ACMD41_RETRIES + 1);
  localparam int PW = $clog2(RESP_TIMEOUT + 1);
  localparam int CW = $clog2(DUMMY_BYTES + 8);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(ACMD41_RETRIES);
  localparam logic [PW-1:0] POLL_LAST  = PW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_BYTES - 1);

  typedef enum logic [7:0] {
    S_IDLE   = 8'h00,
    S_DUMMY  = 8'h10,
    S_CMD0   = 8'h20,
    S_CMD8   = 8'h30,
    S_CMD55  = 8'h40,
    S_ACMD41 = 8'h41,
    S_CMD58  = 8'h50,
    S_READY  = 8'h70,
    S_ERROR  = 8'hFF
  } major_t;

  typedef enum logic [1:0] {P_SEND, P_POLL, P_TAIL, P_GAP} phase_t;

  function automatic logic [7:0] cmd_byte(input major_t st, input logic [2:0] idx);
    logic [47:0] frame;
    logic [7:0]  b;
    case (st)
      S_CMD0:   frame = 48'h400000000095;
      S_CMD8:   frame = 48'h48000001AA87;
      S_CMD55:  frame = 48'h770000000065;
      S_ACMD41: frame = 48'h694000000077;
      S_CMD58:  frame = 48'h7A00000000FD;
      default:  frame = 48'hFFFFFFFFFFFF;
    endcase
    case (idx)
      3'd0:    b = frame[47:40];
      3'd1:    b = frame[39:32];
      3'd2:    b = frame[31:24];
      3'd3:    b = frame[23:16];
      3'd4:    b = frame[15:8];
      3'd5:    b = frame[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  function automatic major_t after_gap(input major_t st, input logic acmd_ok);
    major_t nx;
    case (st)
      S_CMD0:   nx = S_CMD8;
      S_CMD8:   nx = S_CMD55;
      S_CMD55:  nx = S_ACMD41;
      S_ACMD41: nx = acmd_ok ? S_CMD58 : S_CMD55;
      S_CMD58:  nx = S_READY;
      default:  nx = S_ERROR;
    endcase
    return nx;
  endfunction

  major_t          st_q, st_d, nx;
  phase_t          ph_q, ph_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic            acmd_ok_q, acmd_ok_d, tail_bad_q, tail_bad_d, ccs_q, ccs_d;
  logic            kick_q, kick_d, busy_q, busy_d;
  logic            spi_start_q, spi_start_d, cs_n_q, cs_n_d;
  logic [7:0]      spi_tx_q, spi_tx_d;
  logic            ready_q, ready_d, error_q, error_d, high_cap_q, high_cap_d;
  logic            issue, issue_cs, go_err, go_rdy, to_gap, to_tail, last_tail;
  logic [7:0]      issue_tx;

  always_comb begin
    st_d       = st_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    retry_d    = retry_q;
    acmd_ok_d  = acmd_ok_q;
    tail_bad_d = tail_bad_q;
    ccs_d      = ccs_q;
    kick_d     = 1'b0;
    busy_d     = busy_q;
    spi_start_d = 1'b0;
    spi_tx_d   = spi_tx_q;
    cs_n_d     = cs_n_q;
    ready_d    = ready_q;
    error_d    = error_q;
    high_cap_d = high_cap_q;
    issue      = 1'b0;
    issue_tx   = 8'hFF;
    issue_cs   = 1'b1;
    go_err     = 1'b0;
    go_rdy     = 1'b0;
    to_gap     = 1'b0;
    to_tail    = 1'b0;
    nx         = after_gap(st_q, acmd_ok_q);
    retry_inc  = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);
    last_tail  = (cnt_q[2:0] == 3'd3);

    // Start needs one extra cycle before the first dummy byte goes out
    if (kick_q) begin
      issue = 1'b1;
    end else if (Start && (st_q == S_IDLE || st_q == S_READY || st_q == S_ERROR)) begin
      st_d       = S_DUMMY;
      ph_d       = P_SEND;
      cnt_d      = '0;
      poll_d     = '0;
      retry_d    = '0;
      acmd_ok_d  = 1'b0;
      tail_bad_d = 1'b0;
      ccs_d      = 1'b0;
      ready_d    = 1'b0;
      error_d    = 1'b0;
      high_cap_d = 1'b0;
      kick_d     = 1'b1;
    end else if (busy_q && SpiDone) begin
      busy_d = 1'b0;
      if (st_q == S_DUMMY) begin
        issue = 1'b1;
        if (cnt_q == DUMMY_LAST) begin
          st_d     = S_CMD0;
          ph_d     = P_SEND;
          cnt_d    = '0;
          issue_tx = cmd_byte(S_CMD0, 3'd0);
          issue_cs = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        case (ph_q)
          P_SEND: begin
            issue    = 1'b1;
            issue_cs = 1'b0;
            if (cnt_q[2:0] == 3'd5) begin
              ph_d   = P_POLL;
              poll_d = '0;
            end else begin
              cnt_d    = cnt_q + CW'(1);
              issue_tx = cmd_byte(st_q, cnt_q[2:0] + 3'd1);
            end
          end
          P_POLL: begin
            if (SpiRx == 8'hFF) begin
              if (poll_q == POLL_LAST) begin
                go_err = 1'b1;
              end else begin
                poll_d   = poll_q + PW'(1);
                issue    = 1'b1;
                issue_cs = 1'b0;
              end
            end else begin
              case (st_q)
                S_CMD0:  if (SpiRx == 8'h01) to_gap = 1'b1; else go_err = 1'b1;
                S_CMD8:  if (SpiRx == 8'h01) to_tail = 1'b1; else go_err = 1'b1;
                S_CMD55: if (SpiRx == 8'h00 || SpiRx == 8'h01) to_gap = 1'b1; else go_err = 1'b1;
                S_ACMD41: begin
                  if (SpiRx == 8'h00) begin
                    acmd_ok_d = 1'b1;
                    to_gap    = 1'b1;
                  end else if (SpiRx == 8'h01) begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) go_err = 1'b1;
                    else to_gap = 1'b1;
                  end else begin
                    go_err = 1'b1;
                  end
                end
                S_CMD58: if (SpiRx == 8'h00) to_tail = 1'b1; else go_err = 1'b1;
                default: go_err = 1'b1;
              endcase
            end
          end
          P_TAIL: begin
            // CMD8 tail carries the voltage echo, CMD58 tail carries the OCR
            if (st_q == S_CMD8) begin
              if (cnt_q[2:0] == 3'd2 && SpiRx[3:0] != 4'h1) tail_bad_d = 1'b1;
              if (cnt_q[2:0] == 3'd3 && SpiRx != 8'hAA) tail_bad_d = 1'b1;
            end else if (cnt_q[2:0] == 3'd0) begin
              ccs_d = SpiRx[6];
            end
            if (last_tail) begin
              if (st_q == S_CMD8 && tail_bad_d) begin
                go_err = 1'b1;
              end else begin
                to_gap = 1'b1;
                if (st_q == S_CMD58) high_cap_d = ccs_q;
              end
            end else begin
              cnt_d    = cnt_q + CW'(1);
              issue    = 1'b1;
              issue_cs = 1'b0;
            end
          end
          P_GAP: begin
            if (nx == S_READY) begin
              go_rdy = 1'b1;
            end else begin
              st_d     = nx;
              ph_d     = P_SEND;
              cnt_d    = '0;
              issue    = 1'b1;
              issue_cs = 1'b0;
              issue_tx = cmd_byte(nx, 3'd0);
            end
          end
        endcase
      end
    end

    if (to_gap) begin
      ph_d     = P_GAP;
      issue    = 1'b1;
      issue_cs = 1'b1;
    end
    if (to_tail) begin
      ph_d       = P_TAIL;
      cnt_d      = '0;
      tail_bad_d = 1'b0;
      issue      = 1'b1;
      issue_cs   = 1'b0;
    end
    if (go_err) begin
      st_d     = S_ERROR;
      ph_d     = P_SEND;
      error_d  = 1'b1;
      cs_n_d   = 1'b1;
      spi_tx_d = 8'hFF;
    end
    if (go_rdy) begin
      st_d     = S_READY;
      ph_d     = P_SEND;
      ready_d  = 1'b1;
      cs_n_d   = 1'b1;
      spi_tx_d = 8'hFF;
    end
    if (issue) begin
      spi_start_d = 1'b1;
      spi_tx_d    = issue_tx;
      cs_n_d      = issue_cs;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge CLKin or posedge Reset) begin
    if (Reset) begin
      st_q        <= S_IDLE;
      ph_q        <= P_SEND;
      cnt_q       <= '0;
      poll_q      <= '0;
      retry_q     <= '0;
      acmd_ok_q   <= 1'b0;
      tail_bad_q  <= 1'b0;
      ccs_q       <= 1'b0;
      kick_q      <= 1'b0;
      busy_q      <= 1'b0;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'hFF;
      cs_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      high_cap_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      retry_q     <= retry_d;
      acmd_ok_q   <= acmd_ok_d;
      tail_bad_q  <= tail_bad_d;
      ccs_q       <= ccs_d;
      kick_q      <= kick_d;
      busy_q      <= busy_d;
      spi_start_q <= spi_start_d;
      spi_tx_q    <= spi_tx_d;
      cs_n_q      <= cs_n_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      high_cap_q  <= high_cap_d;
    end
  end

  assign State    = st_q;
  assign SpiStart = spi_start_q;
  assign SpiTx    = spi_tx_q;
  assign CS_n     = cs_n_q;
  assign Ready    = ready_q;
  assign Error    = error_q;
  assign HighCap  = high_cap_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: a scripted SD card is turned into an expected byte
// exchange list, then the DUT is served byte by byte with random handshake delays.
module tb_sd_init_sequencer;

  localparam int RETRIES = 3;

  logic       clk = 1'b0;
  logic       rst, start, spi_done;
  logic [7:0] spi_rx;
  logic       SpiStart, CS_n, Ready, Error, HighCap;
  logic [7:0] SpiTx, State;

  always #5 clk = ~clk;

  sd_init_sequencer #(.DUMMY_BYTES(10), .RESP_TIMEOUT(8), .ACMD41_RETRIES(RETRIES)) dut (
    .CLKin(clk), .Reset(rst), .Start(start), .SpiDone(spi_done), .SpiRx(spi_rx),
    .SpiStart(SpiStart), .SpiTx(SpiTx), .CS_n(CS_n), .State(State),
    .Ready(Ready), .Error(Error), .HighCap(HighCap)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Card script
  logic [7:0]  c_r1_0, c_r1_8, c_r1_55, c_r1_58, c_timeout;
  logic [31:0] c_r7, c_ocr;
  logic [7:0]  c_acmd[$];

  // Expected exchange, produced from the card script
  logic [7:0] exp_tx[$];
  bit         exp_cs[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_st[$];
  logic [7:0] seen_st[$];
  bit         exp_ready, exp_error, exp_hc;

  function automatic void add(input logic [7:0] tx, input bit cs, input logic [7:0] rx);
    exp_tx.push_back(tx);
    exp_cs.push_back(cs);
    rx_q.push_back(rx);
  endfunction

  function automatic void m_err();
    exp_st.push_back(8'hFF);
    exp_error = 1'b1;
  endfunction

  function automatic void m_gap();
    add(8'hFF, 1'b1, 8'hFF);
  endfunction

  function automatic void m_tail(input logic [31:0] t);
    for (int b = 0; b < 4; b++) add(8'hFF, 1'b0, t[31-8*b -: 8]);
  endfunction

  // A command: six frame bytes, some idle polls, then R1 (or a silent card)
  function automatic bit m_cmd(input logic [7:0] code, input logic [47:0] frame, input logic [7:0] r1);
    int np;
    exp_st.push_back(code);
    for (int b = 0; b < 6; b++) add(frame[47-8*b -: 8], 1'b0, 8'hFF);
    if (code == c_timeout) begin
      for (int p = 0; p < 8; p++) add(8'hFF, 1'b0, 8'hFF);
      m_err();
      return 1'b0;
    end
    np = int'($urandom_range(0, 7));
    for (int p = 0; p < np; p++) add(8'hFF, 1'b0, 8'hFF);
    add(8'hFF, 1'b0, r1);
    return 1'b1;
  endfunction

  function automatic void model_run();
    int tries;
    int k;
    logic [7:0] r;
    exp_tx.delete(); exp_cs.delete(); rx_q.delete(); exp_st.delete();
    exp_ready = 1'b0; exp_error = 1'b0; exp_hc = 1'b0;
    exp_st.push_back(8'h10);
    for (int d = 0; d < 10; d++) add(8'hFF, 1'b1, 8'hFF);
    if (!m_cmd(8'h20, 48'h400000000095, c_r1_0)) return;
    if (c_r1_0 != 8'h01) begin m_err(); return; end
    m_gap();
    if (!m_cmd(8'h30, 48'h48000001AA87, c_r1_8)) return;
    if (c_r1_8 != 8'h01) begin m_err(); return; end
    m_tail(c_r7);
    if (c_r7[11:8] != 4'h1 || c_r7[7:0] != 8'hAA) begin m_err(); return; end
    m_gap();
    tries = 0;
    k = 0;
    for (int it = 0; it < 64; it++) begin
      if (!m_cmd(8'h40, 48'h770000000065, c_r1_55)) return;
      if (c_r1_55 != 8'h00 && c_r1_55 != 8'h01) begin m_err(); return; end
      m_gap();
      r = (k < c_acmd.size()) ? c_acmd[k] : 8'h01;
      k++;
      if (!m_cmd(8'h41, 48'h694000000077, r)) return;
      if (r == 8'h00) begin m_gap(); break; end
      if (r != 8'h01) begin m_err(); return; end
      tries++;
      if (tries >= RETRIES) begin m_err(); return; end
      m_gap();
    end
    if (!m_cmd(8'h50, 48'h7A00000000FD, c_r1_58)) return;
    if (c_r1_58 != 8'h00) begin m_err(); return; end
    m_tail(c_ocr);
    m_gap();
    exp_st.push_back(8'h70);
    exp_ready = 1'b1;
    exp_hc = c_ocr[30];
  endfunction

  task automatic do_start(input bit spurious);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_state", 32'(State), 32'h10);
    chk("start_no_req_yet", 32'(SpiStart), 32'h0);
    seen_st.delete();
    seen_st.push_back(State);
    if (spurious) spi_done = 1'b1;
    @(negedge clk); spi_done = 1'b0;
    chk("first_req", 32'(SpiStart), 32'h1);
    chk("first_cs", 32'(CS_n), 32'h1);
  endtask

  task automatic serve(input int maxdly, input bit stop_acmd_poll, input bit start_in_cmd8, output bit stopped);
    int n, w, bad, dly;
    logic [7:0] hold_tx, last;
    logic hold_cs;
    bit injected;
    n = exp_tx.size();
    stopped = 1'b0;
    injected = 1'b0;
    last = State;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (SpiStart !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      if (SpiStart !== 1'b1) begin
        chk($sformatf("byte_request[%0d]", i), 32'(SpiStart), 32'h1);
        stopped = 1'b1;
        return;
      end
      if (stop_acmd_poll && State == 8'h41 && exp_tx[i] == 8'hFF && !exp_cs[i]) begin
        stopped = 1'b1;
        return;
      end
      chk($sformatf("tx[%0d]", i), 32'(SpiTx), 32'(exp_tx[i]));
      chk($sformatf("cs[%0d]", i), 32'(CS_n), 32'(exp_cs[i]));
      hold_tx = SpiTx;
      hold_cs = CS_n;
      bad = 0;
      dly = int'($urandom_range(1, maxdly));
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (SpiStart !== 1'b0 || SpiTx !== hold_tx || CS_n !== hold_cs) bad++;
        if (start_in_cmd8 && !injected && State == 8'h30) begin
          start = 1'b1;
          injected = 1'b1;
        end
      end
      chk($sformatf("hold[%0d]", i), 32'(bad), 32'h0);
      spi_done = 1'b1;
      spi_rx = rx_q[i];
      @(negedge clk);
      spi_done = 1'b0;
      start = 1'b0;
      spi_rx = 8'($urandom);
      if (State !== last) begin seen_st.push_back(State); last = State; end
      if (i < n - 1) chk($sformatf("turnaround[%0d]", i), 32'(SpiStart), 32'h1);
    end
  endtask

  task automatic finish_checks(input string name);
    int extra;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (SpiStart !== 1'b0) extra++;
    end
    chk({name, "_no_more_req"}, 32'(extra), 32'h0);
    chk({name, "_state"}, 32'(State), 32'(exp_st[$]));
    chk({name, "_ready"}, 32'(Ready), 32'(exp_ready));
    chk({name, "_error"}, 32'(Error), 32'(exp_error));
    chk({name, "_highcap"}, 32'(HighCap), 32'(exp_hc));
    chk({name, "_cs_idle"}, 32'(CS_n), 32'h1);
    chk({name, "_state_count"}, 32'(seen_st.size()), 32'(exp_st.size()));
    for (int s = 0; s < seen_st.size() && s < exp_st.size(); s++)
      chk($sformatf("%s_visit[%0d]", name, s), 32'(seen_st[s]), 32'(exp_st[s]));
  endtask

  task automatic spurious_idle();
    logic [7:0] st;
    int bad;
    st = State;
    bad = 0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); spi_done = 1'b1; spi_rx = 8'($urandom);
      @(negedge clk); spi_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (SpiStart !== 1'b0 || State !== st) bad++;
      end
    end
    chk("spurious_ignored", 32'(bad), 32'h0);
  endtask

  task automatic good_card();
    c_timeout = 8'h00; c_r1_0 = 8'h01; c_r1_8 = 8'h01; c_r7 = 32'h000001AA;
    c_r1_55 = 8'h01; c_r1_58 = 8'h00; c_ocr = 32'hC0FF8000;
    c_acmd.delete();
    c_acmd.push_back(8'h01); c_acmd.push_back(8'h01); c_acmd.push_back(8'h00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stopped;
    logic [7:0] nom_states [11] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h41, 8'h40, 8'h41, 8'h40, 8'h41, 8'h50, 8'h70};
    rst = 1'b1; start = 1'b0; spi_done = 1'b0; spi_rx = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(State), 32'h0);
    chk("rst_cs", 32'(CS_n), 32'h1);
    chk("rst_spistart", 32'(SpiStart), 32'h0);
    chk("rst_tx", 32'(SpiTx), 32'hFF);
    chk("rst_ready", 32'(Ready), 32'h0);
    chk("rst_error", 32'(Error), 32'h0);
    chk("rst_highcap", 32'(HighCap), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    spurious_idle();

    // Nominal SDHC card
    good_card();
    model_run();
    do_start(1'b0);
    serve(3, 1'b0, 1'b0, stopped);
    finish_checks("nominal");
    for (int s = 0; s < 11 && s < seen_st.size(); s++)
      chk($sformatf("nominal_required[%0d]", s), 32'(seen_st[s]), 32'(nom_states[s]));
    spurious_idle();

    // CMD0 never answered
    good_card();
    c_timeout = 8'h20;
    model_run();
    do_start(1'b0);
    serve(2, 1'b0, 1'b0, stopped);
    finish_checks("cmd0_timeout");
    spurious_idle();

    // Wrong CMD8 check pattern
    good_card();
    c_r7 = 32'h00000155;
    model_run();
    do_start(1'b0);
    serve(2, 1'b0, 1'b0, stopped);
    finish_checks("bad_cmd8");

    // Card stays busy forever
    good_card();
    c_acmd.delete();
    model_run();
    do_start(1'b0);
    serve(2, 1'b0, 1'b0, stopped);
    finish_checks("acmd41_exhaust");

    // Randomized cards with long, random handshake delays
    for (int it = 0; it < 4; it++) begin
      int mode;
      int nb;
      mode = int'($urandom_range(0, 5));
      good_card();
      c_r1_55 = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h00;
      c_ocr = {1'b1, 1'($urandom_range(0, 1)), 30'($urandom)};
      c_acmd.delete();
      nb = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) c_acmd.push_back(8'h01);
      c_acmd.push_back(8'h00);
      if (mode == 3) c_timeout = 8'h50;
      if (mode == 4) c_r1_0 = 8'h05;
      if (mode == 5) c_r1_58 = 8'h01;
      model_run();
      do_start(1'b1);
      serve(40, 1'b0, 1'b0, stopped);
      finish_checks("stress");
      spurious_idle();
    end

    // Reset while ACMD41 is polling, with a stray Start during CMD8
    good_card();
    model_run();
    do_start(1'b0);
    serve(3, 1'b1, 1'b1, stopped);
    chk("reached_acmd41_poll", 32'(stopped), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(State), 32'h0);
    chk("async_rst_cs", 32'(CS_n), 32'h1);
    chk("async_rst_spistart", 32'(SpiStart), 32'h0);
    chk("async_rst_tx", 32'(SpiTx), 32'hFF);
    chk("async_rst_ready", 32'(Ready), 32'h0);
    chk("async_rst_error", 32'(Error), 32'h0);
    chk("async_rst_highcap", 32'(HighCap), 32'h0);
    @(negedge clk); spi_done = 1'b1;
    @(negedge clk); spi_done = 1'b0; rst = 1'b0;
    begin
      int extra;
      extra = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (SpiStart !== 1'b0) extra++;
      end
      chk("post_reset_quiet", 32'(extra), 32'h0);
    end
    model_run();
    do_start(1'b0);
    serve(5, 1'b0, 1'b0, stopped);
    finish_checks("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
